// File: rtl/customized_div_seq_if.sv
// customized_div_seq_if: operand/result handshake bundle for the sequential float divider.
interface customized_div_seq_if #(
    parameter int MA = 23,
    parameter int MB = 23,
    parameter int MR = 23
);
    logic          in_valid;
    logic          in_ready;
    logic [MA+8:0] dividend;
    logic [MB+8:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [MR+8:0] result;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/customized_div_seq.sv
// customized_div_seq: multi-cycle restoring divider for custom-width floats, truncating result.
module customized_div_seq #(
    parameter int montissa_len_dividend = 23,
    parameter int montissa_len_divisor  = 23,
    parameter int montissa_len_result   = 23
) (
    input logic clk,
    input logic rst,
    customized_div_seq_if.slave bus
);
    localparam int MA = montissa_len_dividend;
    localparam int MB = montissa_len_divisor;
    localparam int MR = montissa_len_result;
    localparam int W  = (MA > MB ? MA : MB) + 1;
    localparam int CW = $clog2(MR + 2);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t        state;
    logic          sign;
    logic          a_zero;
    logic          b_zero;
    logic [7:0]    ea;
    logic [7:0]    eb;
    logic [W:0]    rem;
    logic [W-1:0]  b;
    logic [MR+1:0] q;
    logic [CW-1:0] cnt;

    logic [W-1:0]  a_init;
    logic [W-1:0]  b_init;
    logic          ge;
    logic [W-1:0]  diff;
    logic [7:0]    e_norm;
    logic [MR-1:0] m_norm;

    // Mantissas are left-aligned so both operands share the same binary point.
    always_comb begin
        a_init = W'({1'b1, bus.dividend[MA-1:0]}) << (W - 1 - MA);
        b_init = W'({1'b1, bus.divisor[MB-1:0]}) << (W - 1 - MB);
        ge     = rem >= {1'b0, b};
        diff   = ge ? W'(rem - {1'b0, b}) : rem[W-1:0];
        e_norm = q[MR+1] ? ea - eb + 8'd127 : ea - eb + 8'd126;
        m_norm = q[MR+1] ? q[MR:1] : q[MR-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
            cnt             <= '0;
            sign            <= 1'b0;
            a_zero          <= 1'b0;
            b_zero          <= 1'b0;
            ea              <= '0;
            eb              <= '0;
            rem             <= '0;
            b               <= '0;
            q               <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign         <= bus.dividend[MA+8] ^ bus.divisor[MB+8];
                    ea           <= bus.dividend[MA+7:MA];
                    eb           <= bus.divisor[MB+7:MB];
                    a_zero       <= bus.dividend[MA+7:0] == '0;
                    b_zero       <= bus.divisor[MB+7:0] == '0;
                    rem          <= {1'b0, a_init};
                    b            <= b_init;
                    q            <= '0;
                    cnt          <= '0;
                    bus.in_ready <= 1'b0;
                    state        <= DIV;
                end
                DIV: begin
                    rem <= {diff, 1'b0};
                    q   <= {q[MR:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MR + 1))
                        state <= NORM;
                end
                NORM: begin
                    bus.result      <= b_zero ? {sign, 8'hFF, MR'(0)} :
                                       a_zero ? {sign, 8'h00, MR'(0)} : {sign, e_norm, m_norm};
                    bus.div_by_zero <= b_zero;
                    bus.out_valid   <= 1'b1;
                    state           <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_customized_div_seq.sv
// tb_customized_div_seq: directed vector table plus backpressure and mid-operation reset sequences.
module tb_customized_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    customized_div_seq_if #(.MA(23), .MB(23), .MR(23)) bus ();

    customized_div_seq #(
        .montissa_len_dividend(23),
        .montissa_len_divisor(23),
        .montissa_len_result(23)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Accepts one operation and waits (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
        chk("out_valid_after_handshake", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0};
        vecs[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        vecs[7]  = '{32'h7F000000, 32'h00800000, 32'h3E000000, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h80000000, 32'hFF800000, 1'b1};
        vecs[10] = '{32'h00400000, 32'h3F800000, 32'h00400000, 1'b0};
        vecs[11] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_div_by_zero", 64'(bus.div_by_zero), 64'd0);
        chk("reset_counter", 64'(dut.cnt), 64'd0);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'd26);
            chk($sformatf("result[%0d]", i), 64'(bus.result), 64'(vecs[i].r));
            chk($sformatf("div_by_zero[%0d]", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            finish_op();
        end

        // Backpressure: result must hold and new operands must be ignored while DONE.
        start_op(32'h40C00000, 32'h40000000, lat);
        chk("bp_latency", 64'(lat), 64'd26);
        held = bus.result;
        chk("bp_result", 64'(held), 64'h40400000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.dividend = 32'h3F800000;
            bus.divisor  = 32'h00000000;
            @(posedge clk);
            #1;
            chk("bp_hold_result", 64'(bus.result), 64'(held));
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("bp_dbz_low", 64'(bus.div_by_zero), 64'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_op();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stray_accept", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of DIV discards the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 32'h40C00000;
        bus.divisor  = 32'h40000000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("rst_mid_in_ready_busy", 64'(bus.in_ready), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_result", 64'(bus.result), 64'd0);
        chk("rst_mid_counter", 64'(dut.cnt), 64'd0);
        start_op(32'h3FC00000, 32'h3FC00000, lat);
        chk("post_rst_latency", 64'(lat), 64'd26);
        chk("post_rst_result", 64'(bus.result), 64'h3F800000);
        chk("post_rst_dbz", 64'(bus.div_by_zero), 64'd0);
        finish_op();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/customized_div_seq.md
CUSTOMIZED_DIV_SEQ -- requirements
Module: customized_div_seq

Interface
REQ-001 SHALL have parameter montissa_len_dividend, default 23, dividend mantissa width MA.
REQ-002 SHALL have parameter montissa_len_divisor, default 23, divisor mantissa width MB.
REQ-003 SHALL have parameter montissa_len_result, default 23, result mantissa width MR.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port dividend  input  MA+9  {sign, exp[7:0] bias 127, mantissa[MA-1:0]}, hidden 1 implied.
REQ-009 SHALL have port divisor  input  MB+9  same layout, MB mantissa bits.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  MR+9  {sign, exp[7:0], mantissa[MR-1:0]}.
REQ-013 SHALL have port div_by_zero  output  1  qualified by out_valid; divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, DIV, NORM, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready; in_valid in other states ignored.
REQ-016 SHALL on accept register sign = dividend sign XOR divisor sign, both exponents, A={1,mant_a}, B={1,mant_b} left-aligned to width max(MA,MB)+1, zero-filled on the right; go to DIV.
REQ-017 SHALL in DIV perform restoring division, one quotient bit per cycle, MSB first, for exactly MR+2 cycles, producing Q = floor(A*2^(MR+1)/B) with Q in [2^MR, 2^(MR+2)); iteration counter counts 0..MR+1 then go to NORM.
REQ-018 SHALL in NORM: if Q[MR+1]=1, mantissa = Q[MR:1], exp = ea - eb + 127; else mantissa = Q[MR-1:0], exp = ea - eb + 126; go to DONE.
REQ-019 SHALL compute exponent modulo 256 (8-bit wrap, no saturation, no overflow flag).
REQ-020 SHALL truncate (no rounding); remainder discarded.
REQ-021 SHALL treat divisor with exp field 0 and mantissa 0 as zero: still full latency, div_by_zero=1, result = {sign, 8'hFF, all-zero mantissa}.
REQ-022 SHALL treat dividend with exp field 0 and mantissa 0 (divisor nonzero) as zero: result = {sign, 8'h00, zero mantissa}, div_by_zero=0.
REQ-023 SHALL give precedence to REQ-021 when both operands are zero.
REQ-024 SHALL not support denormals, infinities or NaN beyond REQ-021/022; other exp-0 or exp-255 inputs are processed as normal numbers.
REQ-025 SHALL in DONE assert out_valid with result and div_by_zero held stable until out_valid && out_ready, then go to IDLE.
REQ-026 SHALL have latency: out_valid asserted MR+3 cycles after the accept edge (MR+2 DIV cycles, 1 NORM cycle); next accept earliest the cycle after output handshake.
REQ-027 SHALL hold out_valid low in IDLE, DIV, NORM.

Reset
REQ-028 SHALL on rst=1 at a clock edge enter IDLE regardless of state, discarding any operation in progress.
REQ-029 SHALL after reset drive in_ready=1, out_valid=0, result=0, div_by_zero=0, iteration counter=0.
REQ-030 SHALL give rst priority over simultaneous in_valid or out_ready.

Verification (defaults MA=MB=MR=23, hex values)
REQ-031 SHALL test 40C00000 / 40000000 -> result 40400000, div_by_zero 0, out_valid 26 cycles after accept.
REQ-032 SHALL test 3F800000 / 3FC00000 (normalize-shift path) -> result 3F2AAAAA (truncated); C0C00000 / 40000000 -> C0400000.
REQ-033 SHALL test 3F800000 / 00000000 -> div_by_zero 1, result 7F800000; 00000000 / 40000000 -> result 00000000.
REQ-034 SHALL test backpressure: out_ready low 10 cycles after out_valid -> result stable, in_ready 0 throughout, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 SHALL test rst asserted mid-DIV -> next cycle in_ready 1, out_valid 0; following 3FC00000 / 3FC00000 -> 3F800000.
